// File: rtl/exu_ldst_resp_pkg.sv
// Shared definitions for the EXU load/store responder: funct3 encodings, FSM states, request checks.
package exu_ldst_resp_pkg;

  localparam int STRB_W = 4;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MREQ  = 2'd1,
    ST_MWAIT = 2'd2,
    ST_RSP   = 2'd3
  } state_t;

  // 1 when the request must be answered with an error instead of a memory access.
  function automatic logic req_bad(input logic [2:0] f3, input logic store, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (f3)
      LSU_B:   bad = 1'b0;
      LSU_H:   bad = off[0];
      LSU_W:   bad = |off;
      LSU_BU:  bad = store;
      LSU_HU:  bad = store | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/exu_ldst_resp_align.sv
// Combinational lane logic: store strobes/data replication and load shift plus extension.
module exu_ldst_resp_align
  import exu_ldst_resp_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        off_i,
  input  logic [31:0]       wdata_i,
  input  logic [31:0]       rdata_i,
  output logic [STRB_W-1:0] wstrb_o,
  output logic [31:0]       wdata_o,
  output logic [31:0]       rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    wstrb_o = '0;
    wdata_o = '0;
    rdata_o = '0;
    shifted = rdata_i >> {off_i, 3'b000};
    case (funct3_i)
      LSU_B, LSU_BU: begin
        wstrb_o = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      LSU_H, LSU_HU: begin
        wstrb_o = 4'b0011 << off_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      LSU_W: begin
        wstrb_o = 4'b1111;
        wdata_o = wdata_i;
      end
      default: ;
    endcase
    case (funct3_i)
      LSU_B:   rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      LSU_BU:  rdata_o = {24'h0, shifted[7:0]};
      LSU_H:   rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      LSU_HU:  rdata_o = {16'h0, shifted[15:0]};
      LSU_W:   rdata_o = shifted;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/exu_ldst_resp.sv
// Single-outstanding RV32I load/store responder driving a word-wide memory port.
// Misaligned/illegal requests answer with an error the cycle after accept, with no memory access.
module exu_ldst_resp
  import exu_ldst_resp_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [AW-1:0]     req_addr,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [DW-1:0]     req_wdata,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req_vld,
  input  logic              mem_req_rdy,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_wen,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_rsp_vld,
  input  logic [DW-1:0]     mem_rdata
);

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [STRB_W-1:0] al_wstrb;
  logic [DW-1:0]     al_wdata;
  logic [DW-1:0]     al_rdata;

  exu_ldst_resp_align u_align (
    .funct3_i (funct3_q),
    .off_i    (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rdata_i  (mem_rdata),
    .wstrb_o  (al_wstrb),
    .wdata_o  (al_wdata),
    .rdata_o  (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      store_q  <= 1'b0;
      funct3_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: if (req_vld) begin
        addr_d   = req_addr;
        store_d  = req_store;
        funct3_d = req_funct3;
        wdata_d  = req_wdata;
        rdata_d  = '0;
        err_d    = req_bad(req_funct3, req_store, req_addr[1:0]);
        state_d  = err_d ? ST_RSP : ST_MREQ;
      end
      ST_MREQ:  if (mem_req_rdy) state_d = ST_MWAIT;
      ST_MWAIT: if (mem_rsp_vld) begin
        rdata_d = store_q ? '0 : al_rdata;
        state_d = ST_RSP;
      end
      ST_RSP:   if (rsp_rdy) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Memory and response outputs are forced to zero outside their owning state.
  always_comb begin
    req_rdy     = (state_q == ST_IDLE);
    mem_req_vld = 1'b0;
    mem_addr    = '0;
    mem_wen     = 1'b0;
    mem_wstrb   = '0;
    mem_wdata   = '0;
    rsp_vld     = 1'b0;
    rsp_rdata   = '0;
    rsp_err     = 1'b0;
    if (state_q == ST_MREQ) begin
      mem_req_vld = 1'b1;
      mem_addr    = {addr_q[AW-1:2], 2'b00};
      mem_wen     = store_q;
      mem_wstrb   = al_wstrb;
      mem_wdata   = al_wdata;
    end
    if (state_q == ST_RSP) begin
      rsp_vld   = 1'b1;
      rsp_rdata = rdata_q;
      rsp_err   = err_q;
    end
  end

endmodule

// File: tb/tb_exu_ldst_resp.sv
// Directed bench for exu_ldst_resp: loads/stores, error path, stalls and mid-transaction reset.
module tb_exu_ldst_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] req_addr;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req_vld;
  logic        mem_req_rdy;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_vld;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  exu_ldst_resp #(.AW(32), .DW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .req_addr    (req_addr),
    .req_store   (req_store),
    .req_funct3  (req_funct3),
    .req_wdata   (req_wdata),
    .rsp_vld     (rsp_vld),
    .rsp_rdy     (rsp_rdy),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_req_vld (mem_req_vld),
    .mem_req_rdy (mem_req_rdy),
    .mem_addr    (mem_addr),
    .mem_wen     (mem_wen),
    .mem_wstrb   (mem_wstrb),
    .mem_wdata   (mem_wdata),
    .mem_rsp_vld (mem_rsp_vld),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end (observed hang, required finish)");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction with a 1-cycle memory; checks the memory request and the response.
  task automatic txn(input string tag, input logic [31:0] a, input logic st, input logic [2:0] f3,
                     input logic [31:0] wd, input logic [31:0] mrd, input logic [3:0] e_strb,
                     input logic [31:0] e_wdata, input logic [31:0] e_rdata);
    int n;
    req_vld = 1'b1; req_addr = a; req_store = st; req_funct3 = f3; req_wdata = wd;
    chk({tag, "_req_rdy"}, {31'h0, req_rdy}, 32'h1);
    cyc();
    req_vld = 1'b0;
    chk({tag, "_mem_vld"},  {31'h0, mem_req_vld}, 32'h1);
    chk({tag, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, "_mem_wen"},  {31'h0, mem_wen}, {31'h0, st});
    chk({tag, "_mem_strb"}, {28'h0, mem_wstrb}, {28'h0, e_strb});
    if (st) chk({tag, "_mem_wdata"}, mem_wdata, e_wdata);
    mem_req_rdy = 1'b1;
    cyc();
    mem_req_rdy = 1'b0;
    chk({tag, "_busy_rdy"}, {31'h0, req_rdy}, 32'h0);
    mem_rsp_vld = 1'b1; mem_rdata = mrd;
    cyc();
    mem_rsp_vld = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    n = 0;
    while (!rsp_vld && n < 10) begin cyc(); n++; end
    chk({tag, "_rsp_vld"},   {31'h0, rsp_vld}, 32'h1);
    chk({tag, "_rsp_rdata"}, rsp_rdata, e_rdata);
    chk({tag, "_rsp_err"},   {31'h0, rsp_err}, 32'h0);
    rsp_rdy = 1'b1;
    cyc();
    rsp_rdy = 1'b0;
    chk({tag, "_rsp_done"}, {31'h0, rsp_vld}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; req_vld = 1'b0; req_addr = '0; req_store = 1'b0; req_funct3 = '0; req_wdata = '0;
    rsp_rdy = 1'b0; mem_req_rdy = 1'b0; mem_rsp_vld = 1'b0; mem_rdata = '0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Reset state
    chk("rst_req_rdy",  {31'h0, req_rdy}, 32'h1);
    chk("rst_rsp_vld",  {31'h0, rsp_vld}, 32'h0);
    chk("rst_rsp_err",  {31'h0, rsp_err}, 32'h0);
    chk("rst_rsp_data", rsp_rdata, 32'h0);
    chk("rst_mem_vld",  {31'h0, mem_req_vld}, 32'h0);
    chk("rst_mem_wen",  {31'h0, mem_wen}, 32'h0);
    chk("rst_mem_strb", {28'h0, mem_wstrb}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wd",   mem_wdata, 32'h0);

    // Loads
    txn("lb",  32'h103, 1'b0, 3'b000, 32'h0, 32'h80AABBCC, 4'b1000, 32'h0, 32'hFFFFFF80);
    txn("lbu", 32'h103, 1'b0, 3'b100, 32'h0, 32'h80AABBCC, 4'b1000, 32'h0, 32'h00000080);
    txn("lh",  32'h102, 1'b0, 3'b001, 32'h0, 32'h7FFF1234, 4'b1100, 32'h0, 32'h00007FFF);
    txn("lh2", 32'h100, 1'b0, 3'b001, 32'h0, 32'h12348001, 4'b0011, 32'h0, 32'hFFFF8001);
    txn("lhu", 32'h100, 1'b0, 3'b101, 32'h0, 32'h12348001, 4'b0011, 32'h0, 32'h00008001);
    txn("lw",  32'h104, 1'b0, 3'b010, 32'h0, 32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D);
    // Stores
    txn("sb",  32'h201, 1'b1, 3'b000, 32'h000000A5, 32'h0, 4'b0010, 32'hA5A5A5A5, 32'h0);
    txn("sh",  32'h202, 1'b1, 3'b001, 32'h1234BEEF, 32'h0, 4'b1100, 32'hBEEFBEEF, 32'h0);

    // Misaligned LW: error next cycle, no memory access
    req_vld = 1'b1; req_addr = 32'h102; req_store = 1'b0; req_funct3 = 3'b010;
    cyc();
    req_vld = 1'b0;
    chk("mis_rsp_vld",  {31'h0, rsp_vld}, 32'h1);
    chk("mis_rsp_err",  {31'h0, rsp_err}, 32'h1);
    chk("mis_rsp_data", rsp_rdata, 32'h0);
    chk("mis_mem_vld",  {31'h0, mem_req_vld}, 32'h0);
    rsp_rdy = 1'b1;
    cyc();
    rsp_rdy = 1'b0;
    chk("mis_done", {31'h0, rsp_vld}, 32'h0);
    chk("mis_mem_vld2", {31'h0, mem_req_vld}, 32'h0);

    // Store with a load-only funct3 is illegal
    req_vld = 1'b1; req_addr = 32'h200; req_store = 1'b1; req_funct3 = 3'b100;
    cyc();
    req_vld = 1'b0;
    chk("ill_rsp_err", {31'h0, rsp_err}, 32'h1);
    chk("ill_mem_vld", {31'h0, mem_req_vld}, 32'h0);
    rsp_rdy = 1'b1;
    cyc();
    rsp_rdy = 1'b0;

    // Memory and response stalls on SW
    req_vld = 1'b1; req_addr = 32'h204; req_store = 1'b1; req_funct3 = 3'b010; req_wdata = 32'h11223344;
    cyc();
    req_vld = 1'b1; req_addr = 32'h300; req_store = 1'b0; req_funct3 = 3'b000;
    for (int i = 0; i < 5; i++) begin
      chk("stl_mem_vld",  {31'h0, mem_req_vld}, 32'h1);
      chk("stl_mem_addr", mem_addr, 32'h204);
      chk("stl_mem_strb", {28'h0, mem_wstrb}, 32'hF);
      chk("stl_mem_wd",   mem_wdata, 32'h11223344);
      chk("stl_req_rdy",  {31'h0, req_rdy}, 32'h0);
      cyc();
    end
    req_vld = 1'b0;
    mem_req_rdy = 1'b1;
    cyc();
    mem_req_rdy = 1'b0;
    mem_rsp_vld = 1'b1;
    cyc();
    mem_rsp_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stl_rsp_vld",  {31'h0, rsp_vld}, 32'h1);
      chk("stl_rsp_data", rsp_rdata, 32'h0);
      chk("stl_rsp_err",  {31'h0, rsp_err}, 32'h0);
      chk("stl_rsp_rdy",  {31'h0, req_rdy}, 32'h0);
      cyc();
    end
    rsp_rdy = 1'b1;
    cyc();
    rsp_rdy = 1'b0;
    chk("stl_one_rsp",  {31'h0, rsp_vld}, 32'h0);
    chk("stl_idle",     {31'h0, req_rdy}, 32'h1);
    cyc();
    chk("stl_one_rsp2", {31'h0, rsp_vld}, 32'h0);
    chk("stl_no_mem",   {31'h0, mem_req_vld}, 32'h0);

    // Reset during MWAIT, then a stale completion
    req_vld = 1'b1; req_addr = 32'h300; req_store = 1'b0; req_funct3 = 3'b010;
    cyc();
    req_vld = 1'b0;
    mem_req_rdy = 1'b1;
    cyc();
    mem_req_rdy = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_req_rdy", {31'h0, req_rdy}, 32'h1);
    chk("mrst_mem_vld", {31'h0, mem_req_vld}, 32'h0);
    chk("mrst_rsp_vld", {31'h0, rsp_vld}, 32'h0);
    mem_rsp_vld = 1'b1; mem_rdata = 32'h55555555;
    cyc();
    mem_rsp_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stale_rsp_vld", {31'h0, rsp_vld}, 32'h0);
      chk("stale_req_rdy", {31'h0, req_rdy}, 32'h1);
      cyc();
    end

    // Still functional afterwards
    txn("post_lbu", 32'h001, 1'b0, 3'b100, 32'h0, 32'h0000FE00, 4'b0010, 32'h0, 32'h000000FE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exu_ldst_resp.md
Name: exu_ldst_resp

Overview:
- Responder end of the EXU load/store request interface. Accepts one ldst request from the EXU load/store datapath and performs the RV32I memory access on a word-wide data-memory port.
- Returns read data aligned and sign- or zero-extended, or an error for misaligned addresses.
- Exactly one transaction outstanding at a time. req_rdy is what the EXU load path uses as its iexec ready.

Parameters:
- AW, 32, byte address width (RV_XLEN)
- DW, 32, data width; fixed at 32, word-wide memory

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- req_vld  in  1  ldst request valid
- req_rdy  out  1  ldst request ready
- req_addr  in  AW  byte address (ALU result)
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_wdata  in  DW  store data, LSB-justified
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  response ready
- rsp_rdata  out  DW  extended load data; 0 for stores
- rsp_err  out  1  misaligned address or illegal funct3
- mem_req_vld  out  1  memory request valid
- mem_req_rdy  in  1  memory request ready
- mem_addr  out  AW  word address, with [1:0] forced to 00
- mem_wen  out  1  write enable
- mem_wstrb  out  4  byte strobes
- mem_wdata  out  DW  lane-shifted store data
- mem_rsp_vld  in  1  read/write completion; arrives one or more cycles after the mem handshake
- mem_rdata  in  DW  raw word read data

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- FSM states: IDLE, MREQ, MWAIT, RSP.
  - Reset: state = IDLE. req_rdy = 1, rsp_vld = 0, rsp_err = 0, rsp_rdata = 0, mem_req_vld = 0, mem_wen = 0, mem_wstrb = 0, mem_addr = 0, mem_wdata = 0.
- IDLE:
  - req_rdy = 1. On req_vld, capture addr, store, funct3 and wdata into registers.
  - Misaligned or illegal request: go to RSP with rsp_err = 1, rsp_rdata = 0. No memory access is issued.
    - Misaligned means H/HU with addr[0] != 0, or W with addr[1:0] != 0.
    - Illegal funct3 means 011, 110 or 111; for stores, additionally 100 and 101.
  - Otherwise go to MREQ.
- MREQ:
  - mem_req_vld = 1; address, strobes and data are driven from registers and held stable while mem_req_rdy = 0.
  - Strobes: B = 0001 << a; H = 0011 << a; W = 1111; a = addr[1:0]. Loads drive the same strobe with mem_wen = 0.
  - mem_wdata = wdata replicated per size: B = {4{wdata[7:0]}}, H = {2{wdata[15:0]}}, W = wdata.
  - On mem_req_rdy, go to MWAIT.
- MWAIT:
  - Wait for mem_rsp_vld. A mem_rsp_vld arriving in the same cycle as the handshake is not legal on this memory port.
  - Load: shift mem_rdata right by 8*a, then extend. B/H sign-extend from bit 7/15; BU/HU zero-extend. Register the result into rsp_rdata.
  - Store: rsp_rdata = 0.
  - Go to RSP.
- RSP:
  - rsp_vld = 1 with data stable until rsp_rdy. On rsp_rdy, go to IDLE.
  - req_rdy = 0 in every state except IDLE. No bypass from RSP straight to a new accept.
- Latency: minimum 3 cycles from req handshake to rsp_vld with a 1-cycle memory (req -> MREQ -> MWAIT -> RSP). An error response is visible in the cycle after the request handshake.
- rst asserted mid-transaction: return to IDLE at once, drop the transaction, deassert mem_req_vld next cycle. Any mem_rsp_vld received while in IDLE is ignored.
- rsp_rdy held low: stay in RSP indefinitely; outputs stable.

Decomposition:
- Shared package (dp.svh / isa.svh): funct3 constants LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU; FSM state enum; strobe width constant.
- One natural sub-module, exu_ldst_align: purely combinational. Computes wstrb and wdata from (funct3, addr[1:0], wdata), and load extension from (funct3, addr[1:0], rdata). Reused by the FSM for both directions.

Test Plan:
- LB at addr 0x103, mem_rdata 0x80AABBCC -> rsp_rdata 0xFFFFFF80, rsp_err 0. LBU at the same address -> 0x00000080.
- LH at 0x102, mem_rdata 0x7FFF1234 -> rsp_rdata 0x00007FFF; mem_addr 0x100, mem_wen 0.
- SB at 0x201, wdata 0x000000A5 -> mem_wstrb 0010, mem_wdata 0xA5A5A5A5, mem_wen 1; rsp_rdata 0.
- LW at 0x102 -> rsp_vld the cycle after accept with rsp_err 1; mem_req_vld never asserted.
- mem_req_rdy held low for 5 cycles, then rsp_rdy held low for 3 cycles -> mem outputs and rsp outputs stay stable, req_rdy stays 0, exactly one response is delivered.
- rst pulsed during MWAIT -> state IDLE, req_rdy 1; a later stale mem_rsp_vld produces no rsp_vld.
